register_bank_2r1w: RTL
=======================

REGISTER_BANK_2R1W -- requirements
Module: register_bank_2r1w

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: data width of every register and port.
REQ-002 The block SHALL have parameter DEPTH, default 16: number of registers.
REQ-003 The block SHALL have parameter ADDR_W, default 4: address width, with DEPTH <= 2**ADDR_W.
REQ-004 The block SHALL have parameter ZERO_R0, default 0: when 1, register 0 reads as zero and ignores writes.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port wr_en, input, 1 bit: write request.
REQ-008 The block SHALL have port wr_addr, input, ADDR_W bits: write address.
REQ-009 The block SHALL have port wr_data, input, WIDTH bits: write data.
REQ-010 The block SHALL have port rd_en, input, 1 bit: read request for both read ports.
REQ-011 The block SHALL have ports rd_addr_a and rd_addr_b, inputs, ADDR_W bits each: read addresses.
REQ-012 The block SHALL have ports rd_data_a and rd_data_b, outputs, WIDTH bits each: registered read data.
REQ-013 The block SHALL have port rd_valid, output, 1 bit: rd_data_a/b hold the result of the previous-cycle rd_en.
REQ-014 The block SHALL have port wr_err, output, 1 bit: sticky flag set by an out-of-range write.

Function
REQ-015 A write SHALL commit wr_data to register wr_addr on the rising edge where wr_en=1 and wr_addr < DEPTH.
REQ-016 Reads SHALL have 1-cycle latency: rd_en=1 at edge N -> rd_data_a/b and rd_valid=1 valid after edge N.
REQ-017 With rd_en=0 at an edge, rd_data_a/b SHALL hold their values and rd_valid SHALL go 0.
REQ-018 Write-first bypass: when wr_en=1 and the read address equals wr_addr on the same edge, that port SHALL return wr_data, not the old contents.
REQ-019 Both read ports SHALL be independent; equal addresses on a and b SHALL return identical data, including under bypass.
REQ-020 With ZERO_R0=1, a write to address 0 SHALL be discarded, and reads of address 0 SHALL return 0 with no bypass.
REQ-021 A read address >= DEPTH SHALL return all zeros on that port.
REQ-022 A write address >= DEPTH SHALL be discarded and SHALL set wr_err=1; wr_err SHALL stay 1 until reset.
REQ-023 Storage SHALL be DEPTH x WIDTH flops. Selection SHALL be a parametrised DEPTH:1 mux per read port, with no hard-coded port list.

Reset
REQ-024 While reset=1, every register, rd_data_a, rd_data_b, rd_valid and wr_err SHALL be 0, immediately and without waiting for clk.
REQ-025 Reset asserted mid-operation SHALL discard any write or read on that edge. The first operation after deassertion SHALL see all-zero contents.

Verification
REQ-026 After reset, write 16*(i+1) to registers 0..15, then read a=i, b=15-i for i=0..15 -> rd_data_a=16*(i+1), rd_data_b=16*(16-i), rd_valid=1 one cycle after each rd_en.
REQ-027 Same edge wr_en=1, wr_addr=5, wr_data=16'hBEEF with rd_en=1, rd_addr_a=rd_addr_b=5 -> both outputs 16'hBEEF next cycle; a later read of 5 returns 16'hBEEF.
REQ-028 With ZERO_R0=1, write 16'h1234 to address 0 and read it in the same and next cycle -> 0 both times. With ZERO_R0=0 -> 16'h1234, bypassed.
REQ-029 With DEPTH=12, write address 13 -> wr_err=1, no register changes; read address 14 -> 0.
REQ-030 Assert reset between clock edges with registers loaded -> outputs 0 immediately. After release, a read of any address returns 0.
REQ-031 rd_en=0 for 3 cycles after a valid read -> rd_valid=0 and rd_data_a/b unchanged.

Source files
------------

// File: rtl/register_bank_2r1w.sv
// Two-read / one-write register bank with registered, write-first read ports.
// Out-of-range writes are dropped and latch a sticky error flag.
module register_bank_2r1w #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              rd_valid,
    output logic              wr_err
);

    // One extra bit so DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0] regs [DEPTH];

    logic wr_in_range;
    logic wr_is_r0;
    logic wr_commit;
    logic [WIDTH-1:0] next_a;
    logic [WIDTH-1:0] next_b;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
    assign wr_is_r0    = ZERO_R0 && (wr_addr == '0);
    assign wr_commit   = wr_en && wr_in_range && !wr_is_r0;

    function automatic logic [WIDTH-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic [WIDTH-1:0]  mux_val
    );
        if ({1'b0, addr} >= DEPTH_L)
            return '0;
        if (ZERO_R0 && (addr == '0))
            return '0;
        // Write-first: a committing write to the same address wins.
        if (wr_commit && (addr == wr_addr))
            return wr_data;
        return mux_val;
    endfunction

    logic [WIDTH-1:0] mux_a;
    logic [WIDTH-1:0] mux_b;

    always_comb begin
        mux_a = '0;
        mux_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr_a == i[ADDR_W-1:0]) mux_a = regs[i];
            if (rd_addr_b == i[ADDR_W-1:0]) mux_b = regs[i];
        end
        next_a = read_port(rd_addr_a, mux_a);
        next_b = read_port(rd_addr_b, mux_b);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_commit && (wr_addr == i[ADDR_W-1:0])) regs[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
            rd_valid  <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data_a <= next_a;
                rd_data_b <= next_b;
            end
            if (wr_en && !wr_in_range) wr_err <= 1'b1;
        end
    end

endmodule
